conv2d_mc: RTL and testbench

- Next-generation 2-D convolution engine: multi-channel, signed int8 operands, parametrised accumulator width.
- Adds per-layer bias, requantisation shift with rounding, optional ReLU, and a busy/done handshake.
- Input tiles are loaded into local DI memory over a 32-bit write port. The engine accumulates across `CIN` channel planes and writes int8 results to local DO memory for 32-bit readout.
- Sits between the DMA/loader and the layer sequencer.

---
 rtl/conv2d_mc_pkg.sv | 22 ++
 rtl/conv2d_mc_if.sv | 18 +
 rtl/conv2d_mc_requant.sv | 52 +++++
 rtl/conv2d_mc.sv | 203 ++++++++++++++++++++
 tb/tb_conv2d_mc.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv2d_mc_pkg.sv
// rtl/conv2d_mc_pkg.sv - shared types, default sizes and helpers for conv2d_mc
package conv_pkg;

  localparam int DSIZE_DEF = 4096;
  localparam int KSIZE_DEF = 5;
  localparam int CIN_DEF   = 4;
  localparam int AW        = $clog2(DSIZE_DEF);
  localparam int TAP_W     = $clog2(KSIZE_DEF * KSIZE_DEF * CIN_DEF);

  typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_t;

  // Smallest accumulator that cannot overflow summing int8*int8 products
  function automatic int min_accw(input int ksize, input int cin);
    return 16 + $clog2(ksize * ksize * cin);
  endfunction

  // Index width for a table of n entries (at least one bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2d_mc_if.sv
// rtl/conv2d_mc_if.sv - memory ports and start/busy/done handshake of conv2d_mc
interface conv2d_mc_if #(parameter int AW = conv_pkg::AW);

  logic [AW-1:0] mi_addr;
  logic [31:0]   mi_data;
  logic          mi_wr;
  logic [AW-1:0] mo_addr;
  logic [31:0]   mo_data;
  logic          start;
  logic          busy;
  logic          done;

  modport master (output mi_addr, mi_data, mi_wr, mo_addr, start,
                  input  mo_data, busy, done);
  modport slave  (input  mi_addr, mi_data, mi_wr, mo_addr, start,
                  output mo_data, busy, done);

endinterface

// File: rtl/conv2d_mc_requant.sv
// rtl/conv2d_mc_requant.sv - bias, round-half-up shift, ReLU and int8 saturation
module conv_requant #(
  parameter int W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic signed [W-1:0] bias_in,
  input  logic [4:0]          shift_in,
  input  logic                relu_in,
  input  logic signed [W-1:0] acc,
  output logic signed [7:0]   q
);

  // Two guard bits: one for the bias add, one for the rounding add
  localparam int VW = W + 2;
  localparam logic signed [VW-1:0] SAT_HI = VW'(127);
  localparam logic signed [VW-1:0] SAT_LO = VW'(-128);

  logic signed [W-1:0]  bias_r;
  logic [4:0]           shift_r;
  logic                 relu_r;
  logic signed [VW-1:0] v_sum;
  logic signed [VW-1:0] v_rnd;
  logic signed [VW-1:0] v_sh;
  logic signed [VW-1:0] v_out;

  // Layer parameters are frozen when the layer starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_r  <= '0;
      shift_r <= '0;
      relu_r  <= 1'b0;
    end else if (load) begin
      bias_r  <= bias_in;
      shift_r <= shift_in;
      relu_r  <= relu_in;
    end
  end

  // Requantise the finished accumulator down to a saturated int8
  always_comb begin
    v_sum = VW'(acc) + VW'(bias_r);
    v_rnd = v_sum + (VW'(1) <<< (shift_r - 5'd1));
    v_sh  = (shift_r != 5'd0) ? (v_rnd >>> shift_r) : v_sum;
    v_out = (relu_r && v_sh[VW-1]) ? '0 : v_sh;
    if (v_out > SAT_HI)      q = 8'h7f;
    else if (v_out < SAT_LO) q = 8'h80;
    else                     q = v_out[7:0];
  end

endmodule

// File: rtl/conv2d_mc.sv
// rtl/conv2d_mc.sv - multi-channel int8 2-D convolution engine with local DI/DO memories
module conv2d_mc
  import conv_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int KSIZE = KSIZE_DEF,
  parameter int CIN   = CIN_DEF,
  parameter int ACCW  = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    cfg_data_w,
  input  logic [7:0]                    cfg_data_h,
  input  logic [7:0]                    cfg_res_w,
  input  logic [7:0]                    cfg_res_h,
  input  logic [3:0]                    cfg_stride_x,
  input  logic [3:0]                    cfg_stride_y,
  input  logic [3:0]                    cfg_k_w,
  input  logic [3:0]                    cfg_k_h,
  input  logic signed [ACCW-1:0]        cfg_bias,
  input  logic [4:0]                    cfg_shift,
  input  logic                          cfg_relu,
  input  logic [8*KSIZE*KSIZE*CIN-1:0]  kernel,
  conv2d_mc_if.slave                    bus
);

  localparam int ADDR_W = $clog2(DSIZE);
  localparam int NTAPS  = KSIZE * KSIZE * CIN;
  localparam int TIDX_W = idx_w(NTAPS);
  localparam int ACC_W  = (ACCW < min_accw(KSIZE, CIN)) ? min_accw(KSIZE, CIN) : ACCW;

  state_t state, state_nxt;
  logic   busy, drain_ph, start_acc, issuing, issue_done;

  logic [7:0]  di_mem [DSIZE];
  logic [7:0]  do_mem [DSIZE];
  logic signed [7:0] w_mem [NTAPS];
  logic [7:0]  dw_r, dh_r, rw_r, rh_r;
  logic [3:0]  sx_r, sy_r, kw_r, kh_r;

  logic [3:0]  kx_cnt, ky_cnt;
  logic [7:0]  c_cnt, ox_cnt, oy_cnt;
  logic        kx_last, ky_last, c_last, ox_last, oy_last;
  logic        tap_first, tap_last_out, tap_last_all;
  logic [31:0] x_pos, y_pos;
  logic [ADDR_W-1:0] s0_addr, s0_oaddr;
  logic [TIDX_W-1:0] s0_widx;

  logic              s1_valid, s1_first, s1_last_out, s1_last_all;
  logic [ADDR_W-1:0] s1_addr, s1_oaddr;
  logic signed [7:0] s1_w;
  logic signed [15:0] s1_prod;
  logic              s2_valid, s2_first, s2_last_out;
  logic [ADDR_W-1:0] s2_oaddr;
  logic signed [15:0] s2_prod;
  logic signed [ACC_W-1:0] acc;
  logic              rq_valid;
  logic [ADDR_W-1:0] rq_addr;
  logic signed [7:0] rq_q;

  assign start_acc = bus.start && (state == IDLE);
  assign issuing   = (state == CALC) && !issue_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      drain_ph <= 1'b0;
    end else begin
      state    <= state_nxt;
      drain_ph <= (state == DRAIN) ? ~drain_ph : 1'b0;
    end
  end

  // Next state: leave CALC once the final tap has cleared the address stage
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = CALC;
      CALC:    if (s1_valid && s1_last_all) state_nxt = DRAIN;
      DRAIN:   if (drain_ph) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    busy = (state == CALC) || (state == DRAIN);
    bus.busy = busy;
    bus.done = (state == DONE);
  end

  // Capture the layer configuration and weights when a layer is accepted
  always_ff @(posedge clk) begin
    if (start_acc) begin
      dw_r <= cfg_data_w;  dh_r <= cfg_data_h;
      rw_r <= cfg_res_w;   rh_r <= cfg_res_h;
      sx_r <= cfg_stride_x; sy_r <= cfg_stride_y;
      kw_r <= cfg_k_w;     kh_r <= cfg_k_h;
      for (int i = 0; i < NTAPS; i++) w_mem[i] <= kernel[8*i +: 8];
    end
  end

  // Loop-end flags and S0 address generation for the current tap
  always_comb begin
    kx_last      = (kx_cnt == kw_r - 4'd1);
    ky_last      = (ky_cnt == kh_r - 4'd1);
    c_last       = (c_cnt == 8'(CIN - 1));
    ox_last      = (ox_cnt == rw_r - 8'd1);
    oy_last      = (oy_cnt == rh_r - 8'd1);
    tap_first    = (kx_cnt == 4'd0) && (ky_cnt == 4'd0) && (c_cnt == 8'd0);
    tap_last_out = kx_last && ky_last && c_last;
    tap_last_all = tap_last_out && ox_last && oy_last;
    x_pos    = 32'(ox_cnt) * 32'(sx_r) + 32'(kx_cnt);
    y_pos    = 32'(oy_cnt) * 32'(sy_r) + 32'(ky_cnt);
    s0_addr  = ADDR_W'(32'(c_cnt) * 32'(dw_r) * 32'(dh_r) + y_pos * 32'(dw_r) + x_pos);
    s0_oaddr = ADDR_W'(32'(oy_cnt) * 32'(rw_r) + 32'(ox_cnt));
    s0_widx  = TIDX_W'(32'(c_cnt) * 32'(KSIZE * KSIZE) + 32'(ky_cnt) * 32'(KSIZE) + 32'(kx_cnt));
  end

  // Walk kx, ky, c, ox, oy (innermost first), one tap per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx_cnt <= '0; ky_cnt <= '0; c_cnt <= '0; ox_cnt <= '0; oy_cnt <= '0;
      issue_done <= 1'b0;
    end else if (start_acc) begin
      kx_cnt <= '0; ky_cnt <= '0; c_cnt <= '0; ox_cnt <= '0; oy_cnt <= '0;
      issue_done <= 1'b0;
    end else if (issuing) begin
      if (tap_last_all) issue_done <= 1'b1;
      if (!kx_last) kx_cnt <= kx_cnt + 4'd1;
      else begin
        kx_cnt <= '0;
        if (!ky_last) ky_cnt <= ky_cnt + 4'd1;
        else begin
          ky_cnt <= '0;
          if (!c_last) c_cnt <= c_cnt + 8'd1;
          else begin
            c_cnt <= '0;
            if (!ox_last) ox_cnt <= ox_cnt + 8'd1;
            else begin
              ox_cnt <= '0;
              oy_cnt <= oy_cnt + 8'd1;
            end
          end
        end
      end
    end
  end

  // S1 operands: DI byte times weight, both signed int8
  always_comb s1_prod = 16'($signed(di_mem[s1_addr])) * 16'(s1_w);

  // Pipeline registers S0->S1->S2, accumulator, and requant-stage valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_first <= 1'b0; s1_last_out <= 1'b0; s1_last_all <= 1'b0;
      s1_addr <= '0; s1_oaddr <= '0; s1_w <= '0;
      s2_valid <= 1'b0; s2_first <= 1'b0; s2_last_out <= 1'b0;
      s2_oaddr <= '0; s2_prod <= '0;
      acc <= '0; rq_valid <= 1'b0; rq_addr <= '0;
    end else begin
      s1_valid    <= issuing;
      s1_first    <= tap_first;
      s1_last_out <= tap_last_out;
      s1_last_all <= tap_last_all;
      s1_addr     <= s0_addr;
      s1_oaddr    <= s0_oaddr;
      s1_w        <= w_mem[s0_widx];
      s2_valid    <= s1_valid;
      s2_first    <= s1_first;
      s2_last_out <= s1_last_out;
      s2_oaddr    <= s1_oaddr;
      s2_prod     <= s1_prod;
      if (s2_valid) acc <= s2_first ? ACC_W'(s2_prod) : acc + ACC_W'(s2_prod);
      rq_valid    <= s2_valid && s2_last_out;
      rq_addr     <= s2_oaddr;
    end
  end

  conv_requant #(.W(ACC_W)) u_requant (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_acc),
    .bias_in  (ACC_W'(cfg_bias)),
    .shift_in (cfg_shift),
    .relu_in  (cfg_relu),
    .acc      (acc),
    .q        (rq_q)
  );

  // DI loads are locked out while a layer runs; DO takes requantised results
  always_ff @(posedge clk) begin
    if (bus.mi_wr && !busy)
      for (int i = 0; i < 4; i++) di_mem[bus.mi_addr + ADDR_W'(i)] <= bus.mi_data[8*i +: 8];
    if (rq_valid) do_mem[rq_addr] <= rq_q;
  end

  assign bus.mo_data = {do_mem[bus.mo_addr + ADDR_W'(3)], do_mem[bus.mo_addr + ADDR_W'(2)],
                        do_mem[bus.mo_addr + ADDR_W'(1)], do_mem[bus.mo_addr]};

endmodule

// File: tb/tb_conv2d_mc.sv
// tb/tb_conv2d_mc.sv - scoreboard bench for conv2d_mc
module tb_conv2d_mc;
  import conv_pkg::*;

  localparam int KS = 5;
  localparam int NC = 2;
  localparam int DS = 4096;
  localparam int AWT = conv_pkg::AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] cfg_data_w, cfg_data_h, cfg_res_w, cfg_res_h;
  logic [3:0] cfg_stride_x, cfg_stride_y, cfg_k_w, cfg_k_h;
  logic signed [23:0] cfg_bias;
  logic [4:0] cfg_shift;
  logic cfg_relu;
  logic [8*KS*KS*NC-1:0] kernel;

  conv2d_mc_if #(.AW(AWT)) bus ();

  conv2d_mc #(.DSIZE(DS), .KSIZE(KS), .CIN(NC), .ACCW(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_data_w(cfg_data_w), .cfg_data_h(cfg_data_h),
    .cfg_res_w(cfg_res_w), .cfg_res_h(cfg_res_h),
    .cfg_stride_x(cfg_stride_x), .cfg_stride_y(cfg_stride_y),
    .cfg_k_w(cfg_k_w), .cfg_k_h(cfg_k_h),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .kernel(kernel), .bus(bus)
  );

  typedef struct { int addr; int val; } exp_t;
  exp_t exp_q[$];
  byte  di_m [DS];
  int   wt [NC][KS][KS];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   aborted;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int golden(input int ox, input int oy);
    longint acc, v;
    int x, y, a, dw, dh;
    dw = int'(cfg_data_w);
    dh = int'(cfg_data_h);
    acc = 0;
    for (int c = 0; c < NC; c++)
      for (int ky = 0; ky < int'(cfg_k_h); ky++)
        for (int kx = 0; kx < int'(cfg_k_w); kx++) begin
          x = ox * int'(cfg_stride_x) + kx;
          y = oy * int'(cfg_stride_y) + ky;
          a = (c * dw * dh + y * dw + x) % DS;
          acc += longint'(di_m[a]) * longint'(wt[c][ky][kx]);
        end
    v = acc + longint'(cfg_bias);
    if (cfg_shift != 0) v = (v + (longint'(1) << (int'(cfg_shift) - 1))) >>> int'(cfg_shift);
    if (cfg_relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic set_cfg(input int dw, input int dh, input int rw, input int rh, input int sx,
                         input int sy, input int kw, input int kh, input int bias,
                         input int shift, input int relu);
    cfg_data_w = 8'(dw); cfg_data_h = 8'(dh); cfg_res_w = 8'(rw); cfg_res_h = 8'(rh);
    cfg_stride_x = 4'(sx); cfg_stride_y = 4'(sy); cfg_k_w = 4'(kw); cfg_k_h = 4'(kh);
    cfg_bias = 24'(bias); cfg_shift = 5'(shift); cfg_relu = relu[0];
  endtask

  task automatic fill_plane(input int c, input int val);
    int n;
    n = int'(cfg_data_w) * int'(cfg_data_h);
    for (int i = 0; i < n; i++) di_m[c * n + i] = byte'(val);
  endtask

  task automatic set_wt(input int c, input int val);
    for (int ky = 0; ky < KS; ky++)
      for (int kx = 0; kx < KS; kx++)
        wt[c][ky][kx] = (ky < int'(cfg_k_h) && kx < int'(cfg_k_w)) ? val : 0;
  endtask

  task automatic pack_kernel();
    kernel = '0;
    for (int c = 0; c < NC; c++)
      for (int ky = 0; ky < KS; ky++)
        for (int kx = 0; kx < KS; kx++)
          kernel[8*(c*KS*KS + ky*KS + kx) +: 8] = 8'(wt[c][ky][kx]);
  endtask

  task automatic load_di(input int nbytes);
    for (int a = 0; a < nbytes; a += 4) begin
      bus.mi_addr = AWT'(a);
      bus.mi_data = {di_m[a+3], di_m[a+2], di_m[a+1], di_m[a]};
      bus.mi_wr = 1'b1;
      @(posedge clk); #1;
    end
    bus.mi_wr = 1'b0;
  endtask

  // Runs one layer; disturb pokes start/mi_wr/cfg mid-run, rst_at>0 aborts with reset
  task automatic run_layer(input bit disturb, input int rst_at, output bit abrt);
    int n_taps, cyc, busy_low;
    exp_t e;
    n_taps = int'(cfg_res_w) * int'(cfg_res_h) * int'(cfg_k_w) * int'(cfg_k_h) * NC;
    for (int oy = 0; oy < int'(cfg_res_h); oy++)
      for (int ox = 0; ox < int'(cfg_res_w); ox++)
        exp_q.push_back('{addr: oy * int'(cfg_res_w) + ox, val: golden(ox, oy)});
    abrt = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    busy_low = 0;
    if (disturb) begin
      cfg_bias = ~cfg_bias; cfg_shift = cfg_shift ^ 5'd5; cfg_relu = ~cfg_relu;
      cfg_res_w = 8'd1; cfg_k_w = 4'd1; kernel = ~kernel;
      bus.mi_addr = '0; bus.mi_data = 32'h7f7f7f7f;
    end
    while (!bus.done && cyc < 3000) begin
      if (cyc <= n_taps + 3 && !bus.busy) busy_low++;
      if (rst_at == cyc) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_done", int'(bus.done), 0);
        rst_n = 1'b1;
        exp_q.delete();
        abrt = 1'b1;
        return;
      end
      bus.start = disturb && (cyc == 5);
      bus.mi_wr = disturb && (cyc == 5);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    bus.mi_wr = 1'b0;
    check("done_cycle", cyc, n_taps + 4);
    check("busy_held", busy_low, 0);
    @(posedge clk); #1;
    check("done_pulse", int'(bus.done), 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.mo_addr = AWT'(e.addr);
      #1;
      check($sformatf("do[%0d]", e.addr), int'($signed(bus.mo_data[7:0])), e.val);
    end
  endtask

  task automatic setup_ramp(input int bias);
    set_cfg(6, 6, 3, 3, 2, 2, 2, 2, bias, 3, 0);
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 6; x++) begin
        di_m[y*6 + x]      = byte'(x + 6*y - 12);
        di_m[36 + y*6 + x] = byte'(20 - 3*x - y);
      end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.mi_wr = 1'b0; bus.mi_addr = '0; bus.mi_data = '0; bus.mo_addr = '0;
    set_cfg(1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
    kernel = '0;
    for (int i = 0; i < DS; i++) di_m[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4x4 ones, 3x3 ones on channel 0 only -> every output 9
    set_cfg(4, 4, 2, 2, 1, 1, 3, 3, 0, 0, 0);
    fill_plane(0, 1); fill_plane(1, 0);
    set_wt(0, 1); set_wt(1, 0); pack_kernel();
    load_di(32);
    run_layer(1'b0, 0, aborted);

    // two channels, 2 and -1 against weights 3 -> 12
    set_cfg(2, 2, 1, 1, 1, 1, 2, 2, 0, 0, 0);
    fill_plane(0, 2); fill_plane(1, -1);
    set_wt(0, 3); set_wt(1, 3); pack_kernel();
    load_di(8);
    run_layer(1'b0, 0, aborted);

    // saturation high, saturation low, then ReLU on the low case
    set_cfg(3, 3, 1, 1, 1, 1, 3, 3, 0, 0, 0);
    fill_plane(0, 127); fill_plane(1, 127);
    set_wt(0, 127); set_wt(1, 127); pack_kernel();
    load_di(20);
    run_layer(1'b0, 0, aborted);
    fill_plane(0, -128); fill_plane(1, -128);
    load_di(20);
    run_layer(1'b0, 0, aborted);
    cfg_relu = 1'b1;
    run_layer(1'b0, 0, aborted);

    // rounding with shift 1: 5 -> 3, -5 -> -2, 5 with bias -6 -> 0
    set_cfg(1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0);
    set_wt(0, 1); set_wt(1, 0); pack_kernel();
    fill_plane(1, 0);
    fill_plane(0, 5);
    load_di(4);
    run_layer(1'b0, 0, aborted);
    fill_plane(0, -5);
    load_di(4);
    run_layer(1'b0, 0, aborted);
    fill_plane(0, 5);
    cfg_bias = -24'sd6;
    load_di(4);
    run_layer(1'b0, 0, aborted);

    // ramp image, stride 2, random weights, with start/mi_wr/cfg pokes mid-run
    setup_ramp(37);
    for (int c = 0; c < NC; c++) begin
      set_wt(c, 0);
      for (int ky = 0; ky < 2; ky++)
        for (int kx = 0; kx < 2; kx++) wt[c][ky][kx] = int'($urandom_range(0, 255)) - 128;
    end
    pack_kernel();
    load_di(72);
    run_layer(1'b1, 0, aborted);

    // reset at cycle 10 of a layer, then the same layer runs to completion
    setup_ramp(-50);
    pack_kernel();
    run_layer(1'b0, 10, aborted);
    check("abort_seen", int'(aborted), 1);
    @(posedge clk); #1;
    run_layer(1'b0, 0, aborted);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
